// File: rtl/quad_pkg.sv
// Shared encodings for the quadrature decoder: Gray states, direction polarity
// and the default glitch-filter length.
package quad_pkg;

   typedef enum logic [1:0] {
      S00 = 2'b00,
      S01 = 2'b01,
      S10 = 2'b10,
      S11 = 2'b11
   } gray_e;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   localparam int unsigned FILT_DEFAULT = 3;

   // Successor of a {A,B} state when channel A leads (forward rotation).
   function automatic gray_e gray_next_up(input gray_e s);
      gray_e n;
      case (s)
         S00:     n = S10;
         S10:     n = S11;
         S11:     n = S01;
         default: n = S00;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// Two-flop synchroniser followed by a stable-count filter: a new level is
// accepted only after FILT consecutive synchronised samples disagree with it.
module quad_sync_filter
   import quad_pkg::*;
#(
   parameter int unsigned FILT = FILT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic       s1_q, s2_q;
   logic       filt_q, filt_d;
   logic [3:0] cnt_q, cnt_d;

   // Accept on the FILT-th disagreeing sample, so the counter only needs FILT-1.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (s2_q != filt_q) begin
         if (cnt_q == 4'(FILT - 1)) begin
            filt_d = s2_q;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         filt_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         s1_q   <= din;
         s2_q   <= s1_q;
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
      end
   end

   assign dout = filt_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: filtered A/B channels are decoded into a one-cycle
// step pulse with direction, a wrapping position count and a sticky error flag.
module quad_decoder
   import quad_pkg::*;
#(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned FILT  = FILT_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             qa,
   input  logic             qb,
   input  logic             en,
   input  logic             clr,
   input  logic             err_clr,
   output logic             step,
   output logic             up_down,
   output logic [CNT_W-1:0] count,
   output logic             err
);

   logic             fa, fb;
   gray_e            cur_q, ref_q;
   logic             armed_q, armed_d;
   logic             step_q, step_d;
   logic             dir_q, dir_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             chg, illegal, fwd;

   quad_sync_filter #(.FILT(FILT)) u_filt_a (.clk(clk), .rst(rst), .din(qa), .dout(fa));
   quad_sync_filter #(.FILT(FILT)) u_filt_b (.clk(clk), .rst(rst), .din(qb), .dout(fb));

   assign chg     = (cur_q != ref_q);
   assign illegal = ((cur_q ^ ref_q) == 2'b11);
   assign fwd     = (cur_q == gray_next_up(ref_q));

   // The first state change only arms; the reference still tracks so en=0 never queues a step.
   always_comb begin
      armed_d = armed_q;
      step_d  = 1'b0;
      dir_d   = dir_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      if (err_clr) begin
         err_d = 1'b0;
      end
      if (chg) begin
         if (!armed_q) begin
            armed_d = 1'b1;
         end else if (illegal) begin
            err_d = 1'b1;
         end else if (en) begin
            step_d = 1'b1;
            dir_d  = fwd ? DIR_UP : DIR_DN;
            cnt_d  = fwd ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
         end
      end
      if (clr) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cur_q   <= S00;
         ref_q   <= S00;
         armed_q <= 1'b0;
         step_q  <= 1'b0;
         dir_q   <= DIR_UP;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         cur_q   <= gray_e'({fa, fb});
         ref_q   <= cur_q;
         armed_q <= armed_d;
         step_q  <= step_d;
         dir_q   <= dir_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign step    = step_q;
   assign up_down = dir_q;
   assign count   = cnt_q;
   assign err     = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: a behavioural model queues each expected
// step (cycle, count, direction); a negedge monitor pops and compares.
module tb_quad_decoder;

   logic        clk = 1'b0;
   logic        rst, qa, qb, en, clr, err_clr;
   logic        step, up_down, err;
   logic [15:0] count;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   typedef struct {
      int          cyc;
      logic [15:0] cnt;
      logic        dir;
   } exp_t;
   exp_t sbq[$];

   logic [1:0]  m_ab;
   logic        m_armed, m_dir, m_err, m_en;
   logic [15:0] m_cnt;

   quad_decoder #(.CNT_W(16), .FILT(3)) dut (
      .clk(clk), .rst(rst), .qa(qa), .qb(qb), .en(en), .clr(clr),
      .err_clr(err_clr), .step(step), .up_down(up_down), .count(count), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [1:0] up_next(input logic [1:0] s);
      case (s)
         2'b00:   return 2'b10;
         2'b10:   return 2'b11;
         2'b11:   return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   always @(negedge clk) begin
      if (rst && step) begin
         chk("step_pending", 32'(sbq.size() != 0), 1);
         if (sbq.size() != 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("step_cycle", 32'(cyc), 32'(e.cyc));
            chk("step_count", 32'(count), 32'(e.cnt));
            chk("step_dir", 32'(up_down), 32'(e.dir));
         end
      end
   end

   // Called at a negedge; drives {qa,qb}=ab for 'hold' cycles, optionally pulsing
   // clr / err_clr on exactly the edge that registers the resulting decode.
   task automatic apply(input logic [1:0] ab, input int hold, input bit pclr, input bit perr);
      int  e;
      int  stop;
      logic dir;
      qa   = ab[1];
      qb   = ab[0];
      e    = cyc + 1;
      stop = cyc + hold;
      if (ab != m_ab) begin
         if (!m_armed) begin
            m_armed = 1'b1;
         end else if ((ab ^ m_ab) == 2'b11) begin
            m_err = 1'b1;
         end else begin
            dir = (ab == up_next(m_ab));
            if (m_en) begin
               m_dir = dir;
               m_cnt = pclr ? 16'h0 : (dir ? m_cnt + 16'h1 : m_cnt - 16'h1);
               sbq.push_back('{e + 6, m_cnt, m_dir});
            end
         end
         m_ab = ab;
      end
      if (pclr) m_cnt = 16'h0;
      if (pclr || perr) begin
         while (cyc < e + 5) @(negedge clk);
         clr     = pclr;
         err_clr = perr;
         @(negedge clk);
         clr     = 1'b0;
         err_clr = 1'b0;
      end
      while (cyc < stop) @(negedge clk);
   endtask

   task automatic pulse(input bit c, input bit ec);
      clr     = c;
      err_clr = ec;
      @(negedge clk);
      clr     = 1'b0;
      err_clr = 1'b0;
      if (c)  m_cnt = 16'h0;
      if (ec) m_err = 1'b0;
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_queue_empty"}, 32'(sbq.size()), 0);
      chk({tag, "_count"}, 32'(count), 32'(m_cnt));
      chk({tag, "_up_down"}, 32'(up_down), 32'(m_dir));
      chk({tag, "_err"}, 32'(err), 32'(m_err));
      chk({tag, "_step_idle"}, 32'(step), 0);
   endtask

   task automatic do_reset(input logic [1:0] ab);
      rst = 1'b0;
      qa  = ab[1];
      qb  = ab[0];
      repeat (3) @(negedge clk);
      chk("rst_count", 32'(count), 0);
      chk("rst_step", 32'(step), 0);
      chk("rst_up_down", 32'(up_down), 1);
      chk("rst_err", 32'(err), 0);
      sbq.delete();
      m_ab    = 2'b00;
      m_armed = 1'b0;
      m_cnt   = 16'h0;
      m_dir   = 1'b1;
      m_err   = 1'b0;
      rst     = 1'b1;
   endtask

   initial begin
      rst = 1'b0; qa = 1'b0; qb = 1'b0; en = 1'b1; clr = 1'b0; err_clr = 1'b0;
      m_en = 1'b1;
      @(negedge clk);
      do_reset(2'b00);

      // First change after reset only arms, then four full forward cycles.
      apply(2'b10, 10, 0, 0);
      for (int i = 0; i < 4; i++) begin
         apply(2'b11, 10, 0, 0);
         apply(2'b01, 10, 0, 0);
         apply(2'b00, 10, 0, 0);
         apply(2'b10, 10, 0, 0);
      end
      check_state("up16");
      chk("up16_abs", 32'(count), 16);

      pulse(1'b1, 1'b0);
      apply(2'b11, 10, 0, 0);
      apply(2'b01, 10, 0, 0);
      apply(2'b11, 10, 0, 0);
      apply(2'b10, 10, 0, 0);
      apply(2'b00, 10, 0, 0);
      check_state("wrap");
      chk("wrap_abs", 32'(count), 32'h0000_FFFF);

      qa = 1'b1;
      repeat (2) @(negedge clk);
      qa = 1'b0;
      repeat (12) @(negedge clk);
      check_state("glitch2");
      apply(2'b10, 3, 0, 0);
      apply(2'b00, 12, 0, 0);
      check_state("glitch3");

      apply(2'b11, 12, 0, 0);
      check_state("illegal");
      pulse(1'b0, 1'b1);
      check_state("err_clr");
      apply(2'b00, 12, 0, 1);
      check_state("err_set_wins");

      do_reset(2'b11);
      apply(2'b11, 12, 0, 0);
      check_state("arm");
      apply(2'b10, 12, 0, 0);
      check_state("arm_step");
      chk("arm_step_abs", 32'(count), 32'h0000_FFFF);

      pulse(1'b1, 1'b0);
      en = 1'b0; m_en = 1'b0;
      apply(2'b11, 10, 0, 0);
      apply(2'b01, 10, 0, 0);
      apply(2'b00, 10, 0, 0);
      apply(2'b10, 10, 0, 0);
      apply(2'b11, 10, 0, 0);
      check_state("en_off");
      en = 1'b1; m_en = 1'b1;
      apply(2'b01, 12, 0, 0);
      check_state("en_on");
      chk("en_on_abs", 32'(count), 1);
      apply(2'b00, 12, 1, 0);
      check_state("clr_step");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Quadrature (A/B) incremental-encoder decoder.
- Synchronises and glitch-filters two asynchronous encoder channels, then decodes Gray-code transitions into a one-cycle step pulse with direction.
- Maintains a wrapping position count.
- Sits upstream of the team's up/down counting logic.
  - It generates the direction/step information that a counter consumes.
  - Its up_down output uses the same polarity: 1 = increment, 0 = decrement.

Parameters:
- CNT_W, 16: width of the position count.
- FILT, 3: consecutive cycles a synchronised channel level must differ from the filtered level before it is accepted. Legal range 1..15.

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset (0 = reset)
- qa  in  1  encoder channel A, asynchronous
- qb  in  1  encoder channel B, asynchronous
- en  in  1  1 = steps update count and pulse step; 0 = track state only
- clr  in  1  synchronous clear of count
- err_clr  in  1  clears sticky err
- step  out  1  one-cycle pulse per valid quadrature transition (when en=1)
- up_down  out  1  direction of the last valid transition: 1 = up, 0 = down
- count  out  CNT_W  position, two's-complement wrap
- err  out  1  sticky illegal-transition flag

Behaviour:
- Reset (rst=0 at a clk edge):
  - Outputs: count=0, step=0, up_down=1, err=0.
  - Internal: sync flops=0, filter counters=0, filtered A/B=00, armed=0.
- Synchroniser: 2-flop per channel; s2 is the second stage.
- Filter, per channel:
  - If s2 != filtered, stable_cnt increments; otherwise it clears to 0.
  - When stable_cnt reaches FILT, filtered takes s2 on that edge and stable_cnt clears.
  - Any pulse on s2 shorter than FILT cycles is discarded.
- Decode: compares the previous filtered {A,B} state with the current one.
  - Up sequence: 00->10->11->01->00 (A leads).
  - Down sequence: the exact reverse.
  - No change: nothing happens.
  - Both bits changed: illegal. err is set, no step, count unchanged, up_down holds.
- Armed flag:
  - The first filtered state change after reset is an initialisation only: no step, no err, sets armed=1.
  - This covers an encoder resting at non-00 out of reset.
- Latency: step and the updated count appear FILT+3 clk edges after the edge that first samples the new qa/qb level. With FILT=3 this is 6.
- On a valid transition with en=1:
  - step=1 for exactly one cycle.
  - up_down updated.
  - count +1 (up) or -1 (down), in the same cycle as step.
- Wrap: 2^CNT_W-1 +1 -> 0; 0 -1 -> 2^CNT_W-1. No saturation.
- en=0: filtered state and the decode reference still advance, so no false step occurs when en rises. step=0, count and up_down held. err still detected.
- clr=1: count=0 next edge, overriding any simultaneous step increment. step still pulses; up_down still updates.
- Simultaneous err_clr and a new illegal transition: set wins, err=1.
- Both channels accepted by their filters on the same edge count as a simultaneous change, i.e. illegal.
- Reset mid-operation: all state returns to reset values within one edge. A partial filter count is discarded.

Decomposition:
- Package quad_pkg:
  - Gray state encoding constants (S00, S10, S11, S01).
  - Direction constants DIR_UP=1, DIR_DN=0.
  - Default FILT.
- Sub-module quad_sync_filter: 2-flop synchroniser plus stable-count filter, one instance per channel. Parameter FILT; ports clk, rst, din, dout.
- Top level holds the armed flag, decode logic, count and err.

Test Plan:
- Reset, then drive 4 clean up cycles (00,10,11,01,00...), each level held 10 clks, en=1 -> 16 step pulses, up_down=1, count=16, err=0. Each step lands 6 clks after its input change (FILT=3).
- From count=2, drive 3 reverse steps -> count=0xFFFF (wrap through 0), up_down=0.
- Glitch: qa pulses high for 2 clks (< FILT) -> no step, count unchanged. A 3-clk pulse -> accepted: one up step, then one down step.
- Illegal: from filtered 00, switch qa and qb together to 11 -> err=1, no step, count held. err_clr=1 -> err=0. Drive err_clr together with another illegal jump -> err stays 1.
- Reset with qa=qb=1 held, then one down step -> first acceptance 00->11 gives no err and no step (arming). Next 11->10 gives one step, count=0xFFFF.
- en=0 during 5 up steps, then en=1 plus 1 up step -> exactly one step, count=1. clr coincident with a step -> count=0, step=1.
